// File: rtl/serial_frame_ctrl.sv
// Framing controller: hunts for a sync byte, buffers len + payload (+ checksum when
// SERIAL_FRAME_CHECKSUM_EN is defined) and releases only checked frames over valid/ready.
module serial_frame_ctrl #(
    parameter int          Width        = 8,
    parameter logic [7:0]  SyncByte     = 8'hA5,
    parameter int          MaxLen       = 16,
    parameter int          LenWidth     = 5,
    parameter int          TimeoutWidth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] rx_data,
    input  logic             rx_finish,
    output logic [Width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code
);
    localparam int AW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [TimeoutWidth-1:0] TMO_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAY,
`ifdef SERIAL_FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    fin_q;
    logic [LenWidth-1:0]     len_q, len_d, idx_q, idx_d, rd_q, rd_d;
    logic [TimeoutWidth-1:0] tmr_q, tmr_d;
    logic                    ok_q, ok_d, err_q, err_d;
    logic [1:0]              code_q, code_d;
    logic                    wr_en;
    logic [Width-1:0]        mem_q [MaxLen];
    logic                    ev;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    logic [Width-1:0]        sum_q, sum_d, csum_chk;
`endif

    assign ev = rx_finish & ~fin_q;

    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = out_valid && (rd_q == len_q - 1'b1);
    assign out_data  = out_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        tmr_d   = tmr_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
        sum_d    = sum_q;
        csum_chk = sum_q + rx_data;
`endif
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (ev && rx_data == SyncByte) state_d = S_LEN;
            end
            S_DRAIN: begin
                tmr_d = '0;
                if (ev) begin
                    err_d  = 1'b1;
                    code_d = 2'b00;
                end
                if (out_ready) begin
                    rd_d = rd_q + 1'b1;
                    if (out_last) state_d = S_IDLE;
                end
            end
            default: begin
                tmr_d = tmr_q + 1'b1;
                // Fires on the edge where tmr would reach all-ones; a coincident byte is dropped.
                if (tmr_q == TMO_ONES - 1'b1) begin
                    tmr_d   = '0;
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                    state_d = S_IDLE;
                end else if (ev) begin
                    tmr_d = '0;
                    case (state_q)
                        S_LEN: begin
                            if (rx_data >= Width'(1) && rx_data <= Width'(MaxLen)) begin
                                len_d   = LenWidth'(rx_data);
                                idx_d   = '0;
                                state_d = S_PAY;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                                sum_d   = rx_data;
`endif
                            end else begin
                                err_d   = 1'b1;
                                code_d  = 2'b01;
                                state_d = S_IDLE;
                            end
                        end
                        S_PAY: begin
                            wr_en = 1'b1;
                            idx_d = idx_q + 1'b1;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                            sum_d = sum_q + rx_data;
                            if (idx_d == len_q) state_d = S_CSUM;
`else
                            if (idx_d == len_q) begin
                                ok_d    = 1'b1;
                                rd_d    = '0;
                                state_d = S_DRAIN;
                            end
`endif
                        end
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        S_CSUM: begin
                            if (csum_chk == '0) begin
                                ok_d    = 1'b1;
                                rd_d    = '0;
                                state_d = S_DRAIN;
                            end else begin
                                err_d   = 1'b1;
                                code_d  = 2'b10;
                                state_d = S_IDLE;
                            end
                        end
`endif
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fin_q   <= 1'b1;
            len_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            tmr_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            fin_q   <= rx_finish;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            tmr_q   <= tmr_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Payload storage is deliberately not reset; indices alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q[AW-1:0]] <= rx_data;
    end
endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Framing controller that sits behind the serial receiver and sequences its byte stream into validated packets. It hunts for a sync byte, then captures a length byte, up to MaxLen payload bytes and an optional checksum into an internal buffer. A packet is released downstream over a valid/ready interface only after it has been fully received and checked. Malformed, corrupt or stalled frames are dropped and reported with an error pulse.

## Interface
- Width, 8, byte width; must match the receiver's data width
- SyncByte, 8'hA5, frame start marker
- MaxLen, 16, maximum payload bytes; buffer depth
- LenWidth, 5, width of length and index counters; must satisfy 2^LenWidth > MaxLen
- TimeoutWidth, 16, width of the inter-byte timeout counter

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  Width  byte from receiver; valid while rx_finish is high
- rx_finish  in  1  receiver done level; each rising edge marks one new byte
- out_data  out  Width  payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  high with the final payload byte of a frame
- frame_ok  out  1  one-cycle pulse when a frame is accepted
- frame_err  out  1  one-cycle pulse when a frame is rejected or a byte is dropped
- err_code  out  2  00 overrun, 01 bad length, 10 bad checksum, 11 timeout; valid when frame_err is high, holds last value otherwise

## Operation
- Byte event: fin_d register samples rx_finish every cycle; fin_d resets to 1. Event = rx_finish & ~fin_d. A level held high for many cycles counts as one byte.
- IDLE: on an event with rx_data == SyncByte go to LEN. Other bytes are ignored without error.
- LEN: on an event, len = rx_data.
  - If 1 <= len <= MaxLen: sum = len, idx = 0, go to PAYLOAD.
  - Otherwise: frame_err with code 01, go to IDLE.
- PAYLOAD: on an event, buf[idx] = rx_data, sum += rx_data (mod 2^Width), idx += 1. When idx reaches len, go to CSUM.
- CSUM: on an event, if (sum + rx_data) mod 2^Width == 0, pulse frame_ok, set rd = 0, go to DRAIN. Otherwise frame_err with code 10, go to IDLE.
- DRAIN:
  - out_valid = 1, out_data = buf[rd], out_last = (rd == len-1).
  - On out_valid & out_ready: rd += 1. If out_last was high, go to IDLE.
  - A byte event in DRAIN is discarded with frame_err, code 00.
- Timeout: tmr is cleared in IDLE and DRAIN and on every byte event. It increments each cycle in LEN, PAYLOAD and CSUM. When tmr reaches all-ones: frame_err with code 11, go to IDLE; an event in that same cycle is ignored.
- Buffer contents are not cleared on error or reset; only indices are reset.

## Timing
- Reset values: out_valid 0, out_last 0, out_data 0, frame_ok 0, frame_err 0, err_code 00, state IDLE, tmr 0, idx 0, rd 0, fin_d 1.
- Byte processing: the byte is consumed at the clock edge where the event is sampled. The state change is visible the next cycle.
- frame_ok, frame_err and err_code are registered. They are high for exactly the cycle after the deciding event or timeout.
- First out_valid appears in the same cycle as frame_ok. With out_ready held at 1, one byte transfers per cycle, so a len-byte frame drains in len cycles.
- out_data, out_last and out_valid are stable while out_valid=1 and out_ready=0.
- Reset mid-frame or mid-drain aborts immediately. No pulse is produced; the next frame needs a fresh sync byte.

## Configuration
- SERIAL_FRAME_CHECKSUM_EN defined: behaviour as above, including the CSUM state and error code 10.
- SERIAL_FRAME_CHECKSUM_EN undefined:
  - CSUM state and sum logic are removed.
  - When idx reaches len, the block pulses frame_ok and enters DRAIN directly.
  - Error code 10 is never produced.
  - Frame format is sync, len, payload.

## Test plan
- Good frame A5 03 11 22 33 97 with out_ready=1 -> one frame_ok pulse, then out_data 11, 22, 33 on consecutive cycles, out_last only with 33.
- Same frame with checksum byte 00 -> frame_err with err_code 10, out_valid never asserted; a following good frame is delivered normally.
- A5 00 and A5 11 (MaxLen=16) -> frame_err with err_code 01 each time; non-sync bytes 3C 5A in IDLE produce no response.
- TimeoutWidth=4: A5 02 then no byte events -> frame_err with err_code 11 at the 15th cycle of stall, state IDLE.
- out_ready=0 in DRAIN and one byte event arrives -> frame_err with err_code 00; out_data and out_last hold; raising out_ready then drains all bytes.
- rst pulse mid-payload, then rx_finish held high 10 cycles per byte for a good frame -> each byte counted once, frame delivered intact.
